impl_seq_checker: RTL and testbench

Hardware evaluator that schedules one antecedent/consequent check at a time over two sampled signals `a` and `b`. The antecedent is a rising edge of `a` with `a` then held high for ANT_LEN cycles. The consequent is `b` held high for CONS_LEN cycles. The block sits beside the datapath as a synthesizable monitor, raising pass/fail/vacuous pulses and keeping saturating counts. It supports overlapping-implication timing and, optionally, parallel "implies" timing.

---
 rtl/impl_seq_checker.sv | 256 +++++++++++++++++++++++++
 tb/tb_impl_seq_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/impl_seq_checker.sv
// impl_seq_checker
//   Synthesizable antecedent/consequent monitor over two sampled signals.
//   Antecedent: rising edge of `a`, with `a` high for ANT_LEN cycles
//   counted from the rise cycle. Consequent: `b` high for CONS_LEN cycles.
//   Only one attempt is evaluated at a time. Each attempt ends with exactly
//   one registered pulse: pass, fail or vacuous.
//
//   Build option: define IMPL_CHK_IMPLIES_EN to add the `mode` port and the
//   PAR state for "implies" timing. In that timing the antecedent and the
//   consequent are both tracked from the start cycle. Without the macro the
//   block checks implication timing only.
//
// Ports
//   clk       sole clock, posedge sampling
//   rst_n     asynchronous active-low reset
//   en        lets a new attempt start (never aborts one in progress)
//   mode      0 = overlapping implication, 1 = implies (only with macro)
//   a, b      antecedent / consequent signals
//   busy      high while an attempt is in progress
//   pass      one-cycle pulse, non-vacuous success
//   fail      one-cycle pulse, failure
//   vacuous   one-cycle pulse, antecedent did not complete
//   pass_cnt  saturating pass count
//   fail_cnt  saturating fail count
//
// state | meaning
// IDLE  | waiting for rise of a with en
// ANTE  | implication: counting a-high cycles
// CONS  | implication: counting b-high cycles after the antecedent matched
// PAR   | implies: a and b tracked together from the start cycle
module impl_seq_checker #(
    parameter int ANT_LEN  = 2,
    parameter int CONS_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef IMPL_CHK_IMPLIES_EN
    input  logic             mode,
`endif
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             vacuous,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int AW = $clog2(ANT_LEN + 1);
    localparam int CW = $clog2(CONS_LEN + 1);
    localparam logic [AW-1:0] ANT_LAST  = AW'(ANT_LEN);
    localparam logic [CW-1:0] CONS_LAST = CW'(CONS_LEN);

`ifdef IMPL_CHK_IMPLIES_EN
    typedef enum logic [1:0] {S_IDLE, S_ANTE, S_CONS, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ANTE, S_CONS} state_t;
`endif

    state_t            state_q, state_d;
    logic              a_q;
    logic [AW-1:0]     ant_cnt_q, ant_cnt_d, ant_base, ant_inc;
    logic [CW-1:0]     cons_cnt_q, cons_cnt_d, cons_base, cons_inc;
    logic              ant_full, cons_full, rose, cons_chk;
    logic              pass_q, pass_d, fail_q, fail_d, vac_q, vac_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
`ifdef IMPL_CHK_IMPLIES_EN
    logic              par_step;
    logic              ant_done_q, ant_done_d, ant_ok_q, ant_ok_d;
    logic              cons_done_q, cons_done_d, cons_ok_q, cons_ok_d;
`endif

    always_comb begin
        rose       = a & ~a_q;
        state_d    = state_q;
        ant_cnt_d  = ant_cnt_q;
        cons_cnt_d = cons_cnt_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        vac_d      = 1'b0;
        cons_chk   = 1'b0;
        // Counts restart from zero whenever an attempt (or its consequent
        // phase) begins in this cycle, so the start cycle itself is counted.
        ant_base   = (state_q == S_IDLE) ? '0 : ant_cnt_q;
        cons_base  = (state_q == S_CONS) ? cons_cnt_q : '0;
`ifdef IMPL_CHK_IMPLIES_EN
        par_step    = 1'b0;
        ant_done_d  = ant_done_q;
        ant_ok_d    = ant_ok_q;
        cons_done_d = cons_done_q;
        cons_ok_d   = cons_ok_q;
        if (state_q == S_PAR) begin
            cons_base = cons_cnt_q;
        end
`endif
        ant_inc   = ant_base + AW'(1);
        cons_inc  = cons_base + CW'(1);
        ant_full  = (ant_inc == ANT_LAST);
        cons_full = (cons_inc == CONS_LAST);

        case (state_q)
            S_IDLE: begin
                if (rose && en) begin
`ifdef IMPL_CHK_IMPLIES_EN
                    if (mode) begin
                        ant_done_d  = 1'b0;
                        ant_ok_d    = 1'b0;
                        cons_done_d = 1'b0;
                        cons_ok_d   = 1'b0;
                        par_step    = 1'b1;
                    end else
`endif
                    // a is high here by definition of rose; with ANT_LEN=1
                    // the antecedent matches immediately.
                    if (ant_full) begin
                        cons_chk = 1'b1;
                    end else begin
                        ant_cnt_d = ant_inc;
                        state_d   = S_ANTE;
                    end
                end
            end
            S_ANTE: begin
                if (!a) begin
                    vac_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (ant_full) begin
                    cons_chk = 1'b1;
                end else begin
                    ant_cnt_d = ant_inc;
                end
            end
            S_CONS: begin
                cons_chk = 1'b1;
            end
`ifdef IMPL_CHK_IMPLIES_EN
            S_PAR: begin
                par_step = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Overlapping timing: the b sample of the match cycle counts.
        if (cons_chk) begin
            if (!b) begin
                fail_d  = 1'b1;
                state_d = S_IDLE;
            end else if (cons_full) begin
                pass_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                cons_cnt_d = cons_inc;
                state_d    = S_CONS;
            end
        end

`ifdef IMPL_CHK_IMPLIES_EN
        if (par_step) begin
            state_d = S_PAR;
            if (!ant_done_d) begin
                if (!a) begin
                    ant_done_d = 1'b1;
                    ant_ok_d   = 1'b0;
                end else begin
                    ant_cnt_d = ant_inc;
                    if (ant_full) begin
                        ant_done_d = 1'b1;
                        ant_ok_d   = 1'b1;
                    end
                end
            end
            if (!cons_done_d) begin
                if (!b) begin
                    cons_done_d = 1'b1;
                    cons_ok_d   = 1'b0;
                end else begin
                    cons_cnt_d = cons_inc;
                    if (cons_full) begin
                        cons_done_d = 1'b1;
                        cons_ok_d   = 1'b1;
                    end
                end
            end
            // A consequent failure waits here until the antecedent resolves;
            // a broken antecedent always wins and makes the attempt vacuous.
            if (ant_done_d && !ant_ok_d) begin
                vac_d   = 1'b1;
                state_d = S_IDLE;
            end else if (ant_done_d && cons_done_d) begin
                pass_d  = cons_ok_d;
                fail_d  = ~cons_ok_d;
                state_d = S_IDLE;
            end
        end
`endif

        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (pass_d && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end
        if (fail_d && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= 1'b0;
            ant_cnt_q   <= '0;
            cons_cnt_q  <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            vac_q       <= 1'b0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
`ifdef IMPL_CHK_IMPLIES_EN
            ant_done_q  <= 1'b0;
            ant_ok_q    <= 1'b0;
            cons_done_q <= 1'b0;
            cons_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a;
            ant_cnt_q   <= ant_cnt_d;
            cons_cnt_q  <= cons_cnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            vac_q       <= vac_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
`ifdef IMPL_CHK_IMPLIES_EN
            ant_done_q  <= ant_done_d;
            ant_ok_q    <= ant_ok_d;
            cons_done_q <= cons_done_d;
            cons_ok_q   <= cons_ok_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign vacuous  = vac_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_impl_seq_checker.sv
// Directed bench for impl_seq_checker (ANT_LEN=2, CONS_LEN=3, CNT_W=2).
// Each vector drives en/a/b(/mode) for one posedge and lists the expected
// {busy, pass, fail, vacuous} just after that edge; counter expectations
// follow from the expected pulses with saturation at 3.
module tb_impl_seq_checker;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             a;
    logic             b;
`ifdef IMPL_CHK_IMPLIES_EN
    logic             mode;
`endif
    logic             busy;
    logic             pass;
    logic             fail;
    logic             vacuous;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    int    n_vec = 0;
    int    n_err = 0;
    int    exp_pass_cnt = 0;
    int    exp_fail_cnt = 0;
    int    cyc_no = 0;
    string scen = "init";

    impl_seq_checker #(
        .ANT_LEN  (2),
        .CONS_LEN (3),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
`ifdef IMPL_CHK_IMPLIES_EN
        .mode     (mode),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .vacuous  (vacuous),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d, expected %0d", scen, tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] exp);
        check({tag, " busy"}, int'(busy), int'(exp[3]));
        check({tag, " pass"}, int'(pass), int'(exp[2]));
        check({tag, " fail"}, int'(fail), int'(exp[1]));
        check({tag, " vacuous"}, int'(vacuous), int'(exp[0]));
        check({tag, " pass_cnt"}, int'(pass_cnt), exp_pass_cnt);
        check({tag, " fail_cnt"}, int'(fail_cnt), exp_fail_cnt);
    endtask

    // exp = {busy, pass, fail, vacuous} after this edge
    task automatic cyc(input logic en_i, input logic a_i, input logic b_i,
                       input logic m_i, input logic [3:0] exp);
        en = en_i;
        a  = a_i;
        b  = b_i;
`ifdef IMPL_CHK_IMPLIES_EN
        mode = m_i;
`endif
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp[2] && exp_pass_cnt < CNT_MAX) exp_pass_cnt++;
        if (exp[1] && exp_fail_cnt < CNT_MAX) exp_fail_cnt++;
        check_outs($sformatf("c%0d", cyc_no), exp);
    endtask

    task automatic do_reset(input string name, input logic a_lvl);
        scen  = name;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = a_lvl;
        b     = 1'b0;
`ifdef IMPL_CHK_IMPLIES_EN
        mode  = 1'b0;
`endif
        exp_pass_cnt = 0;
        exp_fail_cnt = 0;
        cyc_no = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("rst", 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Implication, late drop; a already high while in reset still rises
        do_reset("impl_late_drop", 1'b1);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 0, 0, 0, 4'b0010);
        cyc(1, 0, 0, 0, 4'b0000);

        // Antecedent break, implication
        do_reset("impl_ant_break", 1'b0);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 0, 1, 0, 4'b0001);
        cyc(1, 0, 1, 0, 4'b0000);

        // b low at the match cycle fails (overlapping)
        do_reset("impl_b_at_match", 1'b0);
        cyc(1, 1, 0, 0, 4'b1000);
        cyc(1, 1, 0, 0, 4'b0010);
        cyc(1, 0, 0, 0, 4'b0000);

        // Re-trigger while busy: rise at the resolving edge is ignored
        do_reset("retrigger", 1'b0);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 0, 1, 0, 4'b1000);
        cyc(1, 1, 1, 0, 4'b0100);
        cyc(1, 1, 1, 0, 4'b0000);
        cyc(1, 0, 0, 0, 4'b0000);

        // en low at the rise: no attempt; en dropping mid-attempt: no effect
        do_reset("en_gating", 1'b0);
        cyc(0, 1, 1, 0, 4'b0000);
        cyc(1, 1, 1, 0, 4'b0000);
        cyc(1, 0, 1, 0, 4'b0000);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(0, 1, 1, 0, 4'b1000);
        cyc(0, 0, 1, 0, 4'b1000);
        cyc(0, 0, 1, 0, 4'b0100);
        cyc(0, 0, 0, 0, 4'b0000);

        // Reset during CONS: outputs clear at once, no pulse afterwards
        do_reset("reset_mid", 1'b0);
        cyc(1, 1, 1, 0, 4'b1000);
        cyc(1, 1, 1, 0, 4'b1000);
        #2;
        rst_n = 1'b0;
        exp_pass_cnt = 0;
        exp_fail_cnt = 0;
        #1;
        check_outs("async", 4'b0000);
        do_reset("reset_mid_after", 1'b0);
        cyc(1, 0, 1, 0, 4'b0000);
        cyc(1, 0, 1, 0, 4'b0000);

        // Four passes with a 2-bit counter saturate at 3
        do_reset("saturation", 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 1, 0, 4'b1000);
            cyc(1, 1, 1, 0, 4'b1000);
            cyc(1, 1, 1, 0, 4'b1000);
            cyc(1, 1, 1, 0, 4'b0100);
            cyc(1, 0, 0, 0, 4'b0000);
        end

`ifdef IMPL_CHK_IMPLIES_EN
        // Implies, same stimulus as the late-drop case
        do_reset("implies_pass", 1'b0);
        cyc(1, 1, 1, 1, 4'b1000);
        cyc(1, 1, 1, 1, 4'b1000);
        cyc(1, 1, 1, 1, 4'b0100);
        cyc(1, 0, 0, 1, 4'b0000);

        do_reset("implies_ant_break", 1'b0);
        cyc(1, 1, 1, 1, 4'b1000);
        cyc(1, 0, 1, 1, 4'b0001);
        cyc(1, 0, 1, 1, 4'b0000);

        do_reset("implies_early_fail", 1'b0);
        cyc(1, 1, 1, 1, 4'b1000);
        cyc(1, 1, 0, 1, 4'b0010);
        cyc(1, 0, 0, 1, 4'b0000);

        // Consequent fails at t0, held until the antecedent completes
        do_reset("implies_pending_fail", 1'b0);
        cyc(1, 1, 0, 1, 4'b1000);
        cyc(1, 1, 0, 1, 4'b0010);
        cyc(1, 0, 0, 1, 4'b0000);

        // Pending consequent failure overridden by antecedent break
        do_reset("implies_pending_vac", 1'b0);
        cyc(1, 1, 0, 1, 4'b1000);
        cyc(1, 0, 0, 1, 4'b0001);
        cyc(1, 0, 0, 1, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
